tiny_acc_cpu: RTL and testbench
===============================

# tiny_acc_cpu

Parametrised accumulator CPU: next generation of the team's tiny 8-bit CPU. Adds a writable program memory, wider accumulator, immediate arithmetic, conditional jumps, halt and an explicit step enable. The step enable replaces the divided slow clock, so the whole block runs on one clock. Sits between the oscillator/divider logic (which drives `step`) and the RGB driver (which consumes `out_data`).

## Interface
- `DATA_W`, 8: accumulator and output width, 4..16.
- `ADDR_W`, 4: program counter width, 2..4; memory depth is 2^ADDR_W words of 8 bits.
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `step`, in, 1: execute one instruction on this edge; only honoured in RUN.
- `start`, in, 1: IDLE/HALT → RUN.
- `prog_we`, in, 1: program memory write strobe.
- `prog_addr`, in, ADDR_W: write address.
- `prog_data`, in, 8: write data.
- `out_data`, out, DATA_W: last value written by OUT.
- `out_valid`, out, 1: one-cycle pulse after OUT executes.
- `pc_o`, out, ADDR_W: current PC.
- `running`, out, 1: state == RUN.
- `halted`, out, 1: state == HALT.

## Operation
- Instruction format: opcode `[7:4]`, operand `[3:0]`.
  - Immediates are zero-extended to DATA_W.
  - Jump targets use operand `[ADDR_W-1:0]`.
- Opcodes:
  - 0x0 NOP.
  - 0x1 INC: A+1.
  - 0x2 OUT: `out_data` <= A; `out_valid` pulses.
  - 0x3 LDI: A <= imm.
  - 0x4 ADDI: A <= A+imm; C <= carry out.
  - 0x5 SUBI: A <= A−imm; C <= borrow.
  - 0x6 JMP.
  - 0x7 JZ: jump if Z.
  - 0x8 JC: jump if C.
  - 0x9 DEC: A−1.
  - 0xF HLT.
  - All other opcodes act as NOP.
- Arithmetic is modulo 2^DATA_W.
- Flags:
  - Z <= (new A == 0) on every A-writing opcode (INC, LDI, ADDI, SUBI, DEC).
  - C is written only by ADDI/SUBI.
  - INC/DEC do not change C.
- Non-jump, non-HLT instructions: PC <= PC+1, wrapping from 2^ADDR_W−1 to 0.
- Not-taken jump: PC+1.
- Fetch is an asynchronous read of memory at PC. Fetch and execute complete in the same cycle as `step`.
- Memory power-up contents: even addresses = 0x10 (INC), odd addresses = 0x20 (OUT). Reset does not alter memory.
- State machine:
  - IDLE: after reset. `start` → RUN.
  - RUN: HLT executed → HALT.
  - HALT: `start` → RUN with PC <= 0. A, C and Z are retained.
- `start` in RUN is ignored.
- `step` outside RUN is ignored.
- `prog_we` is accepted only in IDLE/HALT; it is ignored in RUN.
- `prog_we` and `start` on the same edge: the write lands. The first fetch happens on a later edge, so it sees the new word.

## Timing
- Reset values, one edge after `rst_n`=0:
  - State IDLE.
  - PC=0, A=0, Z=0, C=0, LR=0.
  - `out_data`=0, `out_valid`=0, `running`=0, `halted`=0.
- Reset asserted mid-RUN: the next edge forces the reset values. No instruction executes on that edge, even with `step`=1.
- `step` and `start` both high in IDLE: `start` is taken; no instruction executes until the next edge.
- State effects of an instruction (A, flags, PC) are visible on the cycle after the `step` edge.
- OUT latency: `out_data` and `out_valid` are registered and appear 1 cycle after the OUT step edge. `out_valid` lasts exactly 1 cycle.
- HLT: PC holds at the HLT address. `halted`=1 from the next cycle.
- `step` held high executes one instruction per clock.

## Configuration
- `TINY_ACC_CPU_CALL_EN` defined:
  - Adds a 1-entry link register LR (ADDR_W bits).
  - 0xA CALL: LR <= PC+1 (wrapped); PC <= target.
  - 0xB RET: PC <= LR.
  - Nested CALL overwrites LR.
  - RET with no prior CALL returns to 0.
- Undefined: no LR is built; 0xA and 0xB are NOPs (PC+1).

## Test plan
- Power-up program, DATA_W=8: reset, `start`, `step`=1 for 32 cycles → `out_valid` pulses every 2nd cycle with `out_data` 1,2,…,16; `pc_o` wraps 15→0.
- Load [0]=0x3F LDI 15, [1]=0x41 ADDI 1, [2]=0x20 OUT, [3]=0xF0 HLT with DATA_W=4; start, step → `out_data`=0, C=1, Z=1, `halted`=1, `pc_o`=3.
- Countdown [0]=0x33, [1]=0x20, [2]=0x90, [3]=0x75, [4]=0x61, [5]=0xF0 → outputs 3,2,1; halt at PC 5.
- `prog_we` during RUN to addr 0 with 0xF0 → ignored, memory unchanged. Reset mid-run with `step`=1 → reset values, memory intact.
- `step` low for 5 cycles in RUN → PC and A frozen. `start` in HALT → PC=0, A retained.
- With `TINY_ACC_CPU_CALL_EN`: [0]=0xA4, [1]=0x20, [2]=0xF0, [4]=0x37, [5]=0xB0 → `out_data`=7, halt at 2. Without the macro: 0xA4 acts as NOP.

Source files
------------

// File: rtl/tiny_acc_cpu.sv
// Accumulator CPU: single clock, step-enabled execution, writable 8-bit program memory.
// Define TINY_ACC_CPU_CALL_EN to build the link register and the CALL (0xA) / RET (0xB) opcodes.
module tiny_acc_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc_o,
  output logic              running,
  output logic              halted
);

  localparam int HALF = 1 << (ADDR_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic zFlag_q, zFlag_d;
  logic cFlag_q, cFlag_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic outValid_q, outValid_d;
`ifdef TINY_ACC_CPU_CALL_EN
  logic [ADDR_W-1:0] lr_q, lr_d;
`endif

  // Even/odd banks give the alternating INC/OUT power-up image without a reset path.
  logic [7:0] memEven_q [HALF] = '{default: 8'h10};
  logic [7:0] memOdd_q  [HALF] = '{default: 8'h20};

  logic [7:0]        instr;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pcInc;
  logic [DATA_W:0]   sum;

  assign instr  = pc_q[0] ? memOdd_q[pc_q[ADDR_W-1:1]] : memEven_q[pc_q[ADDR_W-1:1]];
  assign opcode = instr[7:4];
  assign imm    = DATA_W'(instr[3:0]);
  assign target = instr[ADDR_W-1:0];
  assign pcInc  = pc_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (prog_we && (state_q != RUN)) begin
      if (prog_addr[0]) memOdd_q[prog_addr[ADDR_W-1:1]] <= prog_data;
      else              memEven_q[prog_addr[ADDR_W-1:1]] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      acc_q      <= '0;
      zFlag_q    <= 1'b0;
      cFlag_q    <= 1'b0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
`ifdef TINY_ACC_CPU_CALL_EN
      lr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      zFlag_q    <= zFlag_d;
      cFlag_q    <= cFlag_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
`ifdef TINY_ACC_CPU_CALL_EN
      lr_q       <= lr_d;
`endif
    end
  end

  // Fetch and execute complete in the step cycle; SUBI borrow falls out as the top bit of the difference.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    acc_d      = acc_q;
    zFlag_d    = zFlag_q;
    cFlag_d    = cFlag_q;
    outData_d  = outData_q;
    outValid_d = 1'b0;
    sum        = '0;
`ifdef TINY_ACC_CPU_CALL_EN
    lr_d       = lr_q;
`endif
    case (state_q)
      IDLE: if (start) state_d = RUN;
      HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (step) begin
          pc_d = pcInc;
          case (opcode)
            4'h1: begin
              acc_d   = acc_q + DATA_W'(1);
              zFlag_d = (acc_d == '0);
            end
            4'h2: begin
              outData_d  = acc_q;
              outValid_d = 1'b1;
            end
            4'h3: begin
              acc_d   = imm;
              zFlag_d = (imm == '0);
            end
            4'h4: begin
              sum     = {1'b0, acc_q} + {1'b0, imm};
              acc_d   = sum[DATA_W-1:0];
              cFlag_d = sum[DATA_W];
              zFlag_d = (sum[DATA_W-1:0] == '0);
            end
            4'h5: begin
              sum     = {1'b0, acc_q} - {1'b0, imm};
              acc_d   = sum[DATA_W-1:0];
              cFlag_d = sum[DATA_W];
              zFlag_d = (sum[DATA_W-1:0] == '0);
            end
            4'h6: pc_d = target;
            4'h7: if (zFlag_q) pc_d = target;
            4'h8: if (cFlag_q) pc_d = target;
            4'h9: begin
              acc_d   = acc_q - DATA_W'(1);
              zFlag_d = (acc_d == '0);
            end
`ifdef TINY_ACC_CPU_CALL_EN
            4'hA: begin
              lr_d = pcInc;
              pc_d = target;
            end
            4'hB: pc_d = lr_q;
`endif
            4'hF: begin
              state_d = HALT;
              pc_d    = pc_q;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign pc_o      = pc_q;
  assign running   = (state_q == RUN);
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_tiny_acc_cpu.sv
// Bench for tiny_acc_cpu: 8-bit and 4-bit instances on shared stimulus, checked every cycle
// against an instruction-level model, plus directed program checks and a random phase.
module tb_tiny_acc_cpu;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic step = 1'b0;
  logic start = 1'b0;
  logic prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;

  logic [7:0] out_data8;
  logic out_valid8, running8, halted8;
  logic [3:0] pc8;
  logic [3:0] out_data4;
  logic out_valid4, running4, halted4;
  logic [3:0] pc4;

  int checks = 0;
  int failures = 0;
  bit modelKnown = 0;
  int outs8[$];

  // Model state per instance: 0 = 8-bit, 1 = 4-bit; states 0 idle, 1 run, 2 halt.
  int mSt[2], mPc[2], mA[2], mZ[2], mC[2], mLr[2], mOut[2], mOv[2];
  int mMem[2][16];

  tiny_acc_cpu #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .step(step), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .out_data(out_data8),
    .out_valid(out_valid8), .pc_o(pc8), .running(running8), .halted(halted8));

  tiny_acc_cpu #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .step(step), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .out_data(out_data4),
    .out_valid(out_valid4), .pc_o(pc4), .running(running4), .halted(halted4));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelEdge(input int k, input bit r, input bit st, input bit sp,
                                    input bit we, input int addr, input int data);
    int mask, s0, op, imm, nxt, w;
    mask = (k == 0) ? 255 : 15;
    if (!r) begin
      mSt[k] = 0; mPc[k] = 0; mA[k] = 0; mZ[k] = 0; mC[k] = 0;
      mLr[k] = 0; mOut[k] = 0; mOv[k] = 0;
      return;
    end
    s0 = mSt[k];
    mOv[k] = 0;
    if (s0 == 0) begin
      if (st) mSt[k] = 1;
    end else if (s0 == 2) begin
      if (st) begin mSt[k] = 1; mPc[k] = 0; end
    end else if (sp) begin
      w = mMem[k][mPc[k]];
      op = w / 16;
      imm = w % 16;
      nxt = (mPc[k] + 1) % 16;
      case (op)
        1: begin mA[k] = (mA[k] + 1) & mask; mZ[k] = (mA[k] == 0); end
        2: begin mOut[k] = mA[k]; mOv[k] = 1; end
        3: begin mA[k] = imm; mZ[k] = (imm == 0); end
        4: begin
          mC[k] = (mA[k] + imm > mask);
          mA[k] = (mA[k] + imm) & mask; mZ[k] = (mA[k] == 0);
        end
        5: begin
          mC[k] = (mA[k] < imm);
          mA[k] = (mA[k] - imm) & mask; mZ[k] = (mA[k] == 0);
        end
        6: nxt = imm;
        7: if (mZ[k] != 0) nxt = imm;
        8: if (mC[k] != 0) nxt = imm;
        9: begin mA[k] = (mA[k] - 1) & mask; mZ[k] = (mA[k] == 0); end
`ifdef TINY_ACC_CPU_CALL_EN
        10: begin mLr[k] = nxt; nxt = imm; end
        11: nxt = mLr[k];
`endif
        15: begin mSt[k] = 2; nxt = mPc[k]; end
        default: ;
      endcase
      mPc[k] = nxt;
    end
    if (we && s0 != 1) mMem[k][addr] = data;
  endfunction

  task automatic applyStimulus(input bit r, input bit st, input bit sp, input bit we,
                               input int addr, input int data);
    rst_n = r; start = st; step = sp; prog_we = we;
    prog_addr = addr[3:0]; prog_data = data[7:0];
    @(posedge clk);
    for (int k = 0; k < 2; k++) modelEdge(k, r, st, sp, we, addr & 15, data & 255);
    if (!r) modelKnown = 1;
    #1;
    if (modelKnown) begin
      checkOutput("pc8", pc8, mPc[0]);
      checkOutput("outData8", out_data8, mOut[0]);
      checkOutput("outValid8", out_valid8, mOv[0]);
      checkOutput("running8", running8, mSt[0] == 1);
      checkOutput("halted8", halted8, mSt[0] == 2);
      checkOutput("pc4", pc4, mPc[1]);
      checkOutput("outData4", out_data4, mOut[1]);
      checkOutput("outValid4", out_valid4, mOv[1]);
      checkOutput("running4", running4, mSt[1] == 1);
      checkOutput("halted4", halted4, mSt[1] == 2);
    end
    if (out_valid8) outs8.push_back(int'(out_data8));
  endtask

  task automatic writeWord(input int addr, input int data);
    applyStimulus(1, 0, 0, 1, addr, data);
  endtask

  task automatic runUntilHalt(input int maxCycles);
    for (int n = 0; n < maxCycles && !(halted8 && halted4); n++)
      applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("haltReached8", halted8, 1);
    checkOutput("haltReached4", halted4, 1);
  endtask

  task automatic checkCountdown();
    checkOutput("countdownLen", outs8.size(), 3);
    for (int i = 0; i < outs8.size() && i < 3; i++)
      checkOutput("countdownVal", outs8[i], 3 - i);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a++) mMem[k][a] = (a % 2 == 0) ? 8'h10 : 8'h20;

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("resetPc", pc8, 0);
    checkOutput("resetOut", out_data8, 0);
    checkOutput("resetRunning", running8, 0);

    // Power-up image: INC/OUT pairs count 1..16 and PC wraps.
    applyStimulus(1, 1, 0, 0, 0, 0);
    outs8.delete();
    for (int i = 0; i < 32; i++) applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("powerUpLen", outs8.size(), 16);
    for (int i = 0; i < outs8.size() && i < 16; i++) checkOutput("powerUpVal", outs8[i], i + 1);
    checkOutput("powerUpWrapPc", pc8, 0);

    // start together with step in IDLE executes nothing.
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("startStepPc", pc8, 0);

    // 4-bit overflow: LDI 15, ADDI 1 -> A=0, C=1, Z=1.
    applyStimulus(0, 0, 0, 0, 0, 0);
    writeWord(0, 8'h3F); writeWord(1, 8'h41); writeWord(2, 8'h20); writeWord(3, 8'hF0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    runUntilHalt(20);
    checkOutput("ovfOut4", out_data4, 0);
    checkOutput("ovfPc4", pc4, 3);
    checkOutput("ovfOut8", out_data8, 16);
    writeWord(0, 8'h85); writeWord(1, 8'hF0); writeWord(5, 8'hF0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    runUntilHalt(20);
    checkOutput("carryJump4", pc4, 5);
    checkOutput("carryJump8", pc8, 1);
    writeWord(0, 8'h75);
    applyStimulus(1, 1, 0, 0, 0, 0);
    runUntilHalt(20);
    checkOutput("zeroJump4", pc4, 5);
    checkOutput("zeroJump8", pc8, 1);

    // Countdown 3,2,1.
    applyStimulus(0, 0, 0, 0, 0, 0);
    writeWord(0, 8'h33); writeWord(1, 8'h20); writeWord(2, 8'h90);
    writeWord(3, 8'h75); writeWord(4, 8'h61); writeWord(5, 8'hF0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    outs8.delete();
    runUntilHalt(60);
    checkCountdown();
    checkOutput("countdownHaltPc", pc8, 5);

    // Write in RUN ignored, step low freezes, reset mid-run keeps memory.
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 8'hF0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("frozenPc", pc8, 0);
    outs8.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("runWriteIgnoredLen", outs8.size(), 1);
    if (outs8.size() > 0) checkOutput("runWriteIgnored", outs8[0], 3);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("midResetPc", pc8, 0);
    checkOutput("midResetRunning", running8, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    outs8.delete();
    runUntilHalt(60);
    checkCountdown();

    // Restart from HALT keeps A.
    writeWord(0, 8'h37); writeWord(1, 8'hF0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    runUntilHalt(20);
    writeWord(0, 8'h20);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("restartPc", pc8, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    checkOutput("retainedA8", out_data8, 7);
    checkOutput("retainedA4", out_data4, 7);

    // CALL/RET program (NOPs when the feature is not built).
    applyStimulus(0, 0, 0, 0, 0, 0);
    writeWord(0, 8'hA4); writeWord(1, 8'h20); writeWord(2, 8'hF0);
    writeWord(4, 8'h37); writeWord(5, 8'hB0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    outs8.delete();
    runUntilHalt(30);
    checkOutput("callHaltPc", pc8, 2);
    checkOutput("callOutLen", outs8.size(), 1);
`ifdef TINY_ACC_CPU_CALL_EN
    if (outs8.size() > 0) checkOutput("callOut", outs8[0], 7);
`else
    if (outs8.size() > 0) checkOutput("callOut", outs8[0], 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 15), $urandom_range(0, 255));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
